// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath blocks: current width,
// window FSM states and the saturating current adder.
package snn_pkg;

    localparam int CUR_W_DEF = 4;

    typedef enum logic {
        IDLE,
        COUNT
    } win_state_t;

    // Adds two currents one bit wider than they are, then clamps at full scale.
    function automatic logic [CUR_W_DEF-1:0] sat_add(
        input logic [CUR_W_DEF-1:0] a,
        input logic [CUR_W_DEF-1:0] b
    );
        logic [CUR_W_DEF:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CUR_W_DEF] ? {CUR_W_DEF{1'b1}} : sum[CUR_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/syn_trace.sv
// Leaky synaptic trace: the current halves every cycle, and each incoming
// spike adds the synaptic weight, clamped at full scale.
module syn_trace
    import snn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spike_in,
    input  logic [CUR_W_DEF-1:0] weight,
    output logic [CUR_W_DEF-1:0] current_out
);

    logic [CUR_W_DEF-1:0] kick;

    assign kick = spike_in ? weight : '0;

    // NOTE: registers are written with <= so every flop samples the pre-edge
    // value of its neighbours; blocking = here would chain updates in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_out <= '0;
        end else begin
            current_out <= sat_add(current_out >> 1, kick);
        end
    end

endmodule

// File: rtl/spike_decoder.sv
// Spike-link receiver: leaky synaptic current for the next neuron stage plus a
// windowed spike-rate count delivered over a valid/ready handshake.
module spike_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5,
    // The trace datapath is sized by the shared package; keep these equal.
    parameter int CUR_W  = CUR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_in,
    input  logic             enable,
    input  logic [CUR_W-1:0] weight,
    output logic [CUR_W-1:0] current_out,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    win_state_t       state, state_n;
    logic [CNT_W-1:0] win_cnt, win_n;
    logic [CNT_W-1:0] spk_cnt, spk_n;
    logic [CNT_W-1:0] spike_inc;
    logic [CNT_W-1:0] count_tot;
    logic             close;

    syn_trace u_trace (
        .clk        (clk),
        .reset      (reset),
        .spike_in   (spike_in),
        .weight     (weight),
        .current_out(current_out)
    );

    assign spike_inc = CNT_W'(spike_in);
    // Count including this cycle's spike; on the closing cycle this is the rate.
    assign count_tot = spk_cnt + spike_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            win_cnt <= '0;
            spk_cnt <= '0;
        end else begin
            state   <= state_n;
            win_cnt <= win_n;
            spk_cnt <= spk_n;
        end
    end

    // NOTE: every output of this block is given a default before the case, so
    // no path leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_n = state;
        win_n   = win_cnt;
        spk_n   = spk_cnt;
        close   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = COUNT;
                    win_n   = CNT_W'(1);
                    spk_n   = spike_inc;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_n = IDLE;
                    win_n   = '0;
                    spk_n   = '0;
                end else if (win_cnt == WIN_LAST) begin
                    // Stay in COUNT: the next cycle is already cycle 0.
                    close = 1'b1;
                    win_n = '0;
                    spk_n = '0;
                end else begin
                    win_n = win_cnt + 1'b1;
                    spk_n = count_tot;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A close always wins over a transfer, so valid never drops on a close.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= close && rate_valid && !rate_ready;
            if (close) begin
                rate       <= count_tot;
                rate_valid <= 1'b1;
            end else if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_decoder.sv
// Self-checking bench for spike_decoder: constant vector table, directed
// window/handshake sequences and a randomized run against a queue-based model.
module tb_spike_decoder;

    localparam int WINDOW = 16;

    logic       clk = 1'b0;
    logic       reset, spike_in, enable, rate_ready;
    logic [3:0] weight;
    logic [3:0] current_out;
    logic [4:0] rate;
    logic       rate_valid, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: values the outputs must show after the next edge.
    int m_cur   = 0;
    int m_rate  = 0;
    bit m_valid = 1'b0;
    bit m_ov    = 1'b0;
    bit win_q[$];

    typedef struct {
        logic       rst, spk, en, rdy;
        logic [3:0] w;
        int         cur, rte;
        bit         vld, ov;
    } vec_t;

    vec_t tbl[$];

    spike_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .spike_in   (spike_in),
        .enable     (enable),
        .weight     (weight),
        .current_out(current_out),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Window contents live in a queue; a full queue is a completed window.
    task automatic model_update(input bit r, s, e, rd, input int w);
        int  sum;
        bit  closed;
        if (r) begin
            m_cur = 0; m_rate = 0; m_valid = 0; m_ov = 0;
            win_q.delete();
        end else begin
            m_cur  = m_cur / 2 + (s ? w : 0);
            if (m_cur > 15) m_cur = 15;
            closed = 1'b0;
            sum    = 0;
            if (e) begin
                win_q.push_back(s);
                if (win_q.size() == WINDOW) begin
                    foreach (win_q[k]) sum += int'(win_q[k]);
                    win_q.delete();
                    closed = 1'b1;
                end
            end else begin
                win_q.delete();
            end
            m_ov = closed && m_valid && !rd;
            if (closed) begin
                m_rate  = sum;
                m_valid = 1'b1;
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, s, e, rd, input int w);
        reset      = r;
        spike_in   = s;
        enable     = e;
        rate_ready = rd;
        weight     = 4'(w);
        model_update(r, s, e, rd, w);
        @(posedge clk);
        #1;
        check("model current_out", int'(current_out), m_cur);
        check("model rate", int'(rate), m_rate);
        check("model rate_valid", int'(rate_valid), int'(m_valid));
        check("model overrun", int'(overrun), int'(m_ov));
    endtask

    task automatic add_vec(input logic rst, spk, en, rdy, input int w,
                           input int cur, rte, input bit vld, ov);
        vec_t v;
        v.rst = rst; v.spk = spk; v.en = en; v.rdy = rdy; v.w = 4'(w);
        v.cur = cur; v.rte = rte; v.vld = vld; v.ov = ov;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; spike_in = 1'b0; enable = 1'b0; rate_ready = 1'b0;
        weight = '0;

        // Reset with every other input active, then decay and saturation.
        add_vec(1, 1, 1, 0, 4,  0, 0, 0, 0);
        add_vec(1, 1, 1, 0, 4,  0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 4,  4, 0, 0, 0);
        add_vec(0, 0, 0, 0, 4,  2, 0, 0, 0);
        add_vec(0, 0, 0, 0, 4,  1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 4,  0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 15, 15, 0, 0, 0);
        add_vec(0, 1, 0, 0, 15, 15, 0, 0, 0);
        add_vec(0, 1, 0, 0, 15, 15, 0, 0, 0);
        add_vec(0, 0, 0, 0, 15, 7, 0, 0, 0);
        add_vec(0, 0, 0, 0, 15, 3, 0, 0, 0);
        add_vec(0, 0, 0, 0, 15, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 15, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].spk, tbl[i].en, tbl[i].rdy, int'(tbl[i].w));
            check($sformatf("vec%0d current_out", i), int'(current_out), tbl[i].cur);
            check($sformatf("vec%0d rate", i), int'(rate), tbl[i].rte);
            check($sformatf("vec%0d rate_valid", i), int'(rate_valid), int'(tbl[i].vld));
            check($sformatf("vec%0d overrun", i), int'(overrun), int'(tbl[i].ov));
        end

        // Ready tied high: even-cycle spikes give 8, the next all-spike window 16.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < WINDOW; i++) begin
            step(0, (i % 2) == 0, 1, 1, 1);
            check("rdyhi w1 valid", int'(rate_valid), (i == WINDOW - 1) ? 1 : 0);
        end
        check("rdyhi w1 rate", int'(rate), 8);
        for (int i = 0; i < WINDOW; i++) begin
            step(0, 1, 1, 1, 1);
            check("rdyhi w2 valid", int'(rate_valid), (i == WINDOW - 1) ? 1 : 0);
        end
        check("rdyhi w2 rate", int'(rate), 16);
        step(0, 0, 0, 1, 1);
        check("rdyhi drain valid", int'(rate_valid), 0);

        // Overrun: unconsumed 3 overwritten by 5.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < WINDOW; i++) step(0, i < 3, 1, 0, 1);
        check("ovr w1 rate", int'(rate), 3);
        check("ovr w1 valid", int'(rate_valid), 1);
        check("ovr w1 overrun", int'(overrun), 0);
        for (int i = 0; i < WINDOW; i++) begin
            step(0, i < 5, 1, 0, 1);
            if (i < WINDOW - 1) check("ovr hold rate", int'(rate), 3);
        end
        check("ovr w2 rate", int'(rate), 5);
        check("ovr w2 valid", int'(rate_valid), 1);
        check("ovr w2 overrun", int'(overrun), 1);
        step(0, 0, 0, 0, 1);
        check("ovr pulse end", int'(overrun), 0);
        check("ovr valid held", int'(rate_valid), 1);
        step(0, 0, 0, 1, 1);
        check("ovr consumed", int'(rate_valid), 0);

        // Close coincident with transfer: new rate loaded, no overrun.
        for (int i = 0; i < WINDOW; i++) step(0, i < 2, 1, 0, 1);
        check("coin w1 rate", int'(rate), 2);
        for (int i = 0; i < WINDOW; i++) step(0, i < 6, 1, i == WINDOW - 1, 1);
        check("coin rate", int'(rate), 6);
        check("coin valid", int'(rate_valid), 1);
        check("coin overrun", int'(overrun), 0);
        step(0, 0, 0, 1, 1);

        // Abort after 7 cycles, then a clean window, then reset mid-window.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, (i % 2) == 0, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        check("abort valid", int'(rate_valid), 0);
        for (int i = 0; i < WINDOW; i++) step(0, i == 3 || i == 10, 1, 0, 1);
        check("abort rate", int'(rate), 2);
        check("abort valid after", int'(rate_valid), 1);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 1);
        step(1, 1, 1, 0, 1);
        check("midrst rate", int'(rate), 0);
        check("midrst valid", int'(rate_valid), 0);
        check("midrst current", int'(current_out), 0);
        for (int i = 0; i < WINDOW; i++) step(0, i == 5, 1, 0, 1);
        check("midrst next rate", int'(rate), 1);
        check("midrst next valid", int'(rate_valid), 1);

        // Randomized traffic against the model.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_decoder.md
Name: spike_decoder

Overview:
- Receiving end of a spike link: consumes the 1-bit spike train from an upstream neuron and turns it back into magnitudes.
- Produces two outputs:
  - a 4-bit leaky synaptic current, suitable as the current input of the next neuron stage;
  - a windowed spike-rate count, delivered over a valid/ready handshake to a readout or host interface.
- Sits between neuron layers, and between the neuron array and the output pins.

Parameters:
- WINDOW, 16: cycles per rate-measurement window; must be >= 2 and <= 2**CNT_W - 1.
- CNT_W, 5: width of the rate count and the rate output.
- CUR_W, 4: width of weight and current_out.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- spike_in  input  1  incoming spike, sampled every cycle
- enable  input  1  rate measurement enable
- weight  input  CUR_W  synaptic weight added per spike
- current_out  output  CUR_W  registered synaptic current
- rate  output  CNT_W  spike count of the last completed window
- rate_valid  output  1  rate holds an unconsumed value
- rate_ready  input  1  consumer accepts rate
- overrun  output  1  one-cycle pulse: an unconsumed rate was overwritten

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: current_out=0, rate=0, rate_valid=0, overrun=0, window counter=0, spike counter=0, FSM=IDLE.
- Reset overrides all other inputs in that cycle.
- Synaptic trace (always active, independent of enable):
  - next = (current_out >> 1) + (spike_in ? weight : 0), saturated at 2**CUR_W-1.
  - Computed at CUR_W+1 bits before saturating.
  - Latency: spike at cycle t is visible on current_out at t+1.
- FSM states: IDLE, COUNT.
  - IDLE: counters held at 0. When enable=1 is sampled, that cycle is window cycle 0; it counts spike_in and moves to COUNT.
  - COUNT, enable=1: win_cnt increments and spk_cnt increments on spike_in.
  - COUNT, enable=0: window abandoned. Counters cleared, go to IDLE, no rate produced. Spike in that cycle is ignored. Pending rate/rate_valid are kept.
- Window close:
  - The cycle with win_cnt==WINDOW-1 is the last cycle; its spike is included.
  - On that edge: rate <= final count, rate_valid <= 1, counters <= 0.
  - If enable stays 1, the next cycle is cycle 0 of the next window; there is no dead cycle.
- Handshake:
  - Transfer occurs when rate_valid && rate_ready.
  - rate_valid falls on the next edge unless a window closes in the same cycle.
  - rate is stable while rate_valid=1 without a transfer, except on overwrite.
- Simultaneous close and transfer: the new rate is loaded, rate_valid stays 1, overrun=0.
- Close with rate_valid=1 and rate_ready=0: rate is overwritten, rate_valid stays 1, overrun=1 for exactly one cycle.
- rate_ready while rate_valid=0 has no effect.
- Rate width: spk_cnt cannot exceed WINDOW, which fits in CNT_W, so no saturation logic is needed.
- Reset mid-window or mid-handshake returns everything to reset values; the partial window is discarded.

Decomposition:
- Shared package snn_pkg holds:
  - CUR_W default constant;
  - FSM state typedef (IDLE, COUNT);
  - function sat_add(a, b) returning a CUR_W-bit saturated sum (reused by neuron blocks).
- One natural sub-module: syn_trace, containing the decay-plus-weight register (clk, reset, spike_in, weight, current_out).
- Window/rate FSM and the handshake logic stay in the top level.

Test Plan:
- Reset: assert reset 2 cycles with spike_in=1, enable=1, rate_ready=0 -> current_out=0, rate=0, rate_valid=0, overrun=0.
- Decay: weight=4, single spike at cycle 0 -> current_out 4, 2, 1, 0 on cycles 1-4.
- Saturation: weight=15, spike_in=1 constantly -> current_out 15, then held at 15 (7+15 saturates). Then spike_in=0 -> 7, 3, 1, 0.
- Rate, ready tied high: enable=1, spike on even window cycles for 16 cycles -> rate=8 with rate_valid high for exactly 1 cycle after cycle 15. Next window (all spikes) -> rate=16.
- Overrun: rate_ready=0, 3 spikes in window 1 -> rate=3, valid=1. 5 spikes in window 2 -> rate=5, overrun pulse 1 cycle, valid held. Raise rate_ready -> valid drops next cycle. Also check close coincident with transfer -> no overrun, valid stays 1.
- Abort: enable=1 for 7 cycles with 4 spikes, then enable=0 -> no rate_valid. Re-enable for a full 16-cycle window with 2 spikes -> rate=2, no stale 4 counted. Reset at window cycle 9 -> next window starts from 0.
